// File: rtl/mul_div.sv
// Iterative RV32 M-extension unit: 32-cycle shift-add multiply, 32-cycle restoring divide.
// Define MUL_DIV_FAST_MUL_EN to use a single-cycle combinational multiplier for opcodes 000-011.
module mul_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      opcode,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sgn_a, sgn_b, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     msum, dtrial;
    logic [2*XLEN-1:0] mul_step, div_step, prod;
    logic [XLEN-1:0]   quo, rem, fin_res;

    // MUL itself needs no sign handling: the low word is sign-agnostic.
    assign sgn_a = (opcode == 3'b001) || (opcode == 3'b010) || (opcode == 3'b100) || (opcode == 3'b110);
    assign sgn_b = (opcode == 3'b001) || (opcode == 3'b100) || (opcode == 3'b110);
    assign a_neg = sgn_a & rs1[XLEN-1];
    assign b_neg = sgn_b & rs2[XLEN-1];
    assign a_mag = a_neg ? ('0 - rs1) : rs1;
    assign b_mag = b_neg ? ('0 - rs2) : rs2;
    assign div0  = opcode[2] && (rs2 == '0);
    assign ovf   = opcode[2] && !opcode[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

`ifdef MUL_DIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fast_prod;
    assign fa        = {sgn_a & rs1[XLEN-1], rs1};
    assign fb        = {sgn_b & rs2[XLEN-1], rs2};
    assign fast_prod = 64'(fa * fb);
`endif

    // Multiply: accumulator high half collects partial sums, low half shifts the multiplier out.
    assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {msum, acc_q[XLEN-1:1]};
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign dtrial   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
    assign div_step = dtrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {dtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod = neg_q  ? ('0 - acc_q) : acc_q;
    assign quo  = neg_q  ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem  = rneg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fin_res = '0;
        case (op_q)
            3'b000:                 fin_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = quo;
            default:                fin_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = opcode;
                    cnt_d  = '0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    // Special cases preload the final quotient/remainder so FIN needs no extra path.
                    if (div0) begin
                        acc_d   = {rs1, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIN;
                    end else if (ovf) begin
                        acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIN;
                    end else if (opcode[2]) begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        state_d = CALC;
                    end else begin
`ifdef MUL_DIV_FAST_MUL_EN
                        acc_d   = fast_prod;
                        neg_d   = 1'b0;
                        state_d = FIN;
`else
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = CALC;
`endif
                    end
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_step : mul_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == '1) state_d = FIN;
            end
            FIN: begin
                result_d = fin_res;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIN);
    assign ready  = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mul_div.sv
// Self-checking bench for mul_div: arithmetic reference model, per-cycle compare, directed and random ops.
module tb_mul_div;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  opcode;
    logic [31:0] rs1, rs2;
    logic        busy, ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mul_div #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .busy(busy), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint            sa, sb, p;
        longint unsigned   ua, ub;
        logic [63:0]       u;
        logic              ov;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin u = ua * ub; return u[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the cycle start is driven (cycle 0) to the cycle ready is high.
    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 2;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MUL_DIV_FAST_MUL_EN
        if (!op[2]) return 2;
`endif
        return 34;
    endfunction

    // Transaction-level model: remaining cycles until ready, pending value, visible result.
    int          m_rem   = 0;
    logic        m_ready = 1'b0;
    logic [31:0] m_res   = '0;
    logic [31:0] m_pend  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_ready = 1'b0; m_res = '0;
        end else if (m_ready) begin
            m_ready = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_ready = 1'b1;
                m_res   = m_pend;
            end
        end else if (start) begin
            m_pend = ref_op(opcode, rs1, rs2);
            m_rem  = lat_of(opcode, rs1, rs2) - 1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",   {31'b0, busy},  {31'b0, (m_rem > 0)});
        chk("cyc_ready",  {31'b0, ready}, {31'b0, m_ready});
        chk("cyc_result", result, m_res);
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        opcode = op; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); n = 1; #1;
        start = 1'b0;
        while (!ready && n < 60) begin
            @(posedge clk); n++; #1;
        end
        chk("latency", n, lat_of(op, a, b));
        r = result;
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] r;
        chk({name, "_model"}, ref_op(op, a, b), exp);
        do_op(op, a, b, r);
        chk(name, r, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r, a, b;
        logic [2:0]  op;
        int          seen;
        rst = 1'b1; start = 1'b0; opcode = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy",   {31'b0, busy},  32'h0);
        chk("reset_ready",  {31'b0, ready}, 32'h0);
        chk("reset_result", result, 32'h0);

        directed("mul_15x10",    3'd0, 32'd15,        32'd10,        32'd150);
        directed("mul_m7x3",     3'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFEB);
        directed("mul_m1xm1",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        directed("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        directed("mulh_m1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        directed("mulhsu_m1x1",  3'd2, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF);
        directed("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        directed("div_20_3",     3'd4, 32'd20,        32'd3,         32'd6);
        directed("div_m20_3",    3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA);
        directed("div_m20_m3",   3'd4, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6);
        directed("rem_20_3",     3'd6, 32'd20,        32'd3,         32'd2);
        directed("rem_m20_3",    3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE);
        directed("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        directed("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        directed("divu_100_7",   3'd5, 32'd100,       32'd7,         32'd14);
        directed("divu_big",     3'd5, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF);
        directed("remu_20_3",    3'd7, 32'd20,        32'd3,         32'd2);
        directed("remu_max_10",  3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5);
        directed("div_by0",      3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF);
        directed("divu_by0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
        directed("rem_by0",      3'd6, 32'd7,         32'd0,         32'd7);
        directed("remu_by0",     3'd7, 32'd7,         32'd0,         32'd7);

        // Result held across idle cycles.
        r = result;
        repeat (5) @(posedge clk);
        #1 chk("hold_result", result, r);

        // Stray start mid-calculation is ignored.
        @(posedge clk); #1;
        opcode = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 opcode = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        while (!ready && seen < 60) begin @(posedge clk); seen++; #1; end
        chk("ignore_start_result", result, 32'd142);

        // Reset mid-calculation aborts with no ready.
        @(posedge clk); #1;
        opcode = 3'd4; rs1 = 32'd12345; rs2 = 32'd17; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy",   {31'b0, busy}, 32'h0);
        chk("abort_result", result, 32'h0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1 if (ready) seen++; end
        chk("abort_no_ready", seen, 0);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op(op, a, b, r);
            chk("rand_result", r, ref_op(op, a, b));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
